snake_body_engine: RTL

Parametrised successor to the single-snake movement datapath. It holds the snake body as a circular segment buffer, initialises the snake, and on each step request moves the head in the current direction. It checks wall and self collision, optionally grows, and streams erase/draw pixels to the VGA plot interface. It sits between the game-tick controller and the VGA adapter.

---
 rtl/snake_body_engine_if.sv | 36 +++
 rtl/snake_body_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine_if.sv
// Control and pixel-stream bundle shared by the game-tick controller,
// the snake body engine and the VGA adapter.
interface snake_body_engine_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int MAX_LEN = 64
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic             init;
    logic             step;
    logic             grow;
    logic [1:0]       dir;
    logic [2:0]       snake_colour;
    logic [2:0]       bg_colour;
    logic             busy;
    logic             done;
    logic             dead;
    logic [LEN_W-1:0] length;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [2:0]       colour;
    logic             plot;

    // Controller side: issues commands, watches status and the pixel stream.
    modport master (
        output init, step, grow, dir, snake_colour, bg_colour,
        input  busy, done, dead, length, x, y, colour, plot
    );

    // Engine side.
    modport slave (
        input  init, step, grow, dir, snake_colour, bg_colour,
        output busy, done, dead, length, x, y, colour, plot
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body engine: circular segment buffer, movement, wall/self collision,
// optional growth, and erase/draw pixel streaming toward the VGA adapter.
module snake_body_engine #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int CELL      = 4,
    parameter int MAX_LEN   = 64,
    parameter int START_X   = 15,
    parameter int START_Y   = 15,
    parameter int START_LEN = 4
) (
    input logic                clk,
    input logic                rst,
    snake_body_engine_if.slave bus
);
    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = PTR_W + 1;
    localparam int CX_W  = $clog2(GRID_W);
    localparam int CY_W  = $clog2(GRID_H);
    localparam int CC_W  = (CELL > 1) ? $clog2(CELL) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_WR, S_INIT_DRAW, S_CALC, S_SCAN,
        S_ERASE, S_ADVANCE, S_DRAW_HEAD, S_FINISH
    } state_e;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef struct packed {
        logic [CX_W-1:0] cx;
        logic [CY_W-1:0] cy;
    } seg_t;

    localparam logic [CC_W-1:0] CC_LAST = CC_W'(CELL - 1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             dead_q, dead_d;
    dir_e             dir_q, dir_d;
    dir_e             req_dir_q, req_dir_d;
    logic             grow_q, grow_d;
    seg_t             cand_q, cand_d;
    seg_t             head_seg_q, head_seg_d;
    seg_t             tail_seg_q, tail_seg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [CC_W-1:0]  col_q, col_d;
    logic [CC_W-1:0]  row_q, row_d;

    seg_t             mem [MAX_LEN];
    seg_t             rd_data_q;
    logic [PTR_W-1:0] rd_addr;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    seg_t             wr_data;

    dir_e             move_dir;
    seg_t             cand_c;
    logic             hit_wall;
    seg_t             init_wr_seg;
    seg_t             init_draw_seg;
    seg_t             pix_seg;
    logic [2:0]       pix_colour;
    logic             plotting;
    logic             cell_last;

    assign cell_last = (col_q == CC_LAST) && (row_q == CC_LAST);

    // Start-position segments: write order runs oldest to head, draw order head to oldest.
    assign init_wr_seg.cx   = CX_W'(START_X - START_LEN + 1) + CX_W'(cnt_q);
    assign init_wr_seg.cy   = CY_W'(START_Y);
    assign init_draw_seg.cx = CX_W'(START_X) - CX_W'(cnt_q);
    assign init_draw_seg.cy = CY_W'(START_Y);

    // Segment buffer: one write port, synchronous read with one cycle of latency.
    // NOTE: the body buffer has no reset; only entries between tail and head are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    // Resolve the move direction (reversal keeps the current heading) and the candidate head.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        move_dir = ((req_dir_q ^ dir_q) == 2'b01) ? dir_q : req_dir_q;
        cand_c   = head_seg_q;
        hit_wall = 1'b0;
        unique case (move_dir)
            DIR_RIGHT: if (head_seg_q.cx == CX_W'(GRID_W - 1)) hit_wall = 1'b1;
                       else cand_c.cx = head_seg_q.cx + 1'b1;
            DIR_LEFT:  if (head_seg_q.cx == '0) hit_wall = 1'b1;
                       else cand_c.cx = head_seg_q.cx - 1'b1;
            DIR_UP:    if (head_seg_q.cy == '0) hit_wall = 1'b1;
                       else cand_c.cy = head_seg_q.cy - 1'b1;
            DIR_DOWN:  if (head_seg_q.cy == CY_W'(GRID_H - 1)) hit_wall = 1'b1;
                       else cand_c.cy = head_seg_q.cy + 1'b1;
            default:   hit_wall = 1'b0;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        len_d      = len_q;
        dead_d     = dead_q;
        dir_d      = dir_q;
        req_dir_d  = req_dir_q;
        grow_d     = grow_q;
        cand_d     = cand_q;
        head_seg_d = head_seg_q;
        tail_seg_d = tail_seg_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        wr_en      = 1'b0;
        wr_addr    = head_q;
        wr_data    = cand_q;
        rd_addr    = tail_q + PTR_W'(cnt_q);

        // Pixel walk inside a cell: column fastest, wrapping back to (0,0) after the last pixel.
        if (state_q == S_INIT_DRAW || state_q == S_ERASE || state_q == S_DRAW_HEAD) begin
            if (col_q == CC_LAST) begin
                col_d = '0;
                row_d = (row_q == CC_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.init) begin
                    cnt_d   = '0;
                    state_d = S_INIT_WR;
                end else if (bus.step && !dead_q && (len_q != '0)) begin
                    req_dir_d = dir_e'(bus.dir);
                    grow_d    = bus.grow;
                    state_d   = S_CALC;
                end
            end
            S_INIT_WR: begin
                wr_en   = 1'b1;
                wr_addr = PTR_W'(cnt_q);
                wr_data = init_wr_seg;
                if (cnt_q == LEN_W'(START_LEN - 1)) begin
                    head_d     = PTR_W'(START_LEN - 1);
                    tail_d     = '0;
                    len_d      = LEN_W'(START_LEN);
                    dead_d     = 1'b0;
                    dir_d      = DIR_RIGHT;
                    head_seg_d = init_wr_seg;
                    cnt_d      = '0;
                    col_d      = '0;
                    row_d      = '0;
                    state_d    = S_INIT_DRAW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INIT_DRAW: begin
                if (cell_last) begin
                    if (cnt_q == LEN_W'(START_LEN - 1)) state_d = S_FINISH;
                    else cnt_d = cnt_q + 1'b1;
                end
            end
            S_CALC: begin
                dir_d  = move_dir;
                grow_d = grow_q && (len_q != LEN_W'(MAX_LEN));
                if (hit_wall) begin
                    dead_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cand_d  = cand_c;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // Data for segment cnt-1 (counted from the tail) arrives while cnt is presented.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q != '0) begin
                    if (cnt_q == LEN_W'(1)) tail_seg_d = rd_data_q;
                    if ((rd_data_q == cand_q) && !((cnt_q == LEN_W'(1)) && !grow_q)) begin
                        dead_d  = 1'b1;
                        state_d = S_FINISH;
                    end else if (cnt_q == len_q) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = grow_q ? S_ADVANCE : S_ERASE;
                    end
                end
            end
            S_ERASE: begin
                if (cell_last) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                wr_en      = 1'b1;
                wr_addr    = head_q + 1'b1;
                head_d     = head_q + 1'b1;
                head_seg_d = cand_q;
                if (grow_q) len_d = len_q + 1'b1;
                else tail_d = tail_q + 1'b1;
                col_d   = '0;
                row_d   = '0;
                state_d = S_DRAW_HEAD;
            end
            S_DRAW_HEAD: begin
                if (cell_last) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state is updated only with non-blocking assignments.
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            len_q      <= '0;
            dead_q     <= 1'b0;
            dir_q      <= DIR_RIGHT;
            req_dir_q  <= DIR_RIGHT;
            grow_q     <= 1'b0;
            cand_q     <= '0;
            head_seg_q <= '0;
            tail_seg_q <= '0;
            cnt_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            len_q      <= len_d;
            dead_q     <= dead_d;
            dir_q      <= dir_d;
            req_dir_q  <= req_dir_d;
            grow_q     <= grow_d;
            cand_q     <= cand_d;
            head_seg_q <= head_seg_d;
            tail_seg_q <= tail_seg_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    // Select the cell and colour being plotted in the current state.
    always_comb begin
        plotting   = 1'b0;
        pix_seg    = cand_q;
        pix_colour = bus.snake_colour;
        unique case (state_q)
            S_INIT_DRAW: begin
                plotting = 1'b1;
                pix_seg  = init_draw_seg;
            end
            S_ERASE: begin
                plotting   = 1'b1;
                pix_seg    = tail_seg_q;
                pix_colour = bus.bg_colour;
            end
            S_DRAW_HEAD: plotting = 1'b1;
            default:     plotting = 1'b0;
        endcase
    end

    assign bus.plot   = plotting;
    assign bus.x      = plotting ? (X_W'(pix_seg.cx) * X_W'(CELL) + X_W'(col_q)) : '0;
    assign bus.y      = plotting ? (Y_W'(pix_seg.cy) * Y_W'(CELL) + Y_W'(row_q)) : '0;
    assign bus.colour = plotting ? pix_colour : 3'd0;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_FINISH);
    assign bus.dead   = dead_q;
    assign bus.length = len_q;
endmodule
